// File: rtl/cpu_types_pkg.sv
// Shared types for the 5-stage MIPS core: hazard FSM states, pipeline control
// bundle and the load-use detector used by the sequencing controller.
package cpu_types_pkg;

    localparam int unsigned HAZ_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        HALT
    } hazard_state_t;

    // One cycle's worth of pipeline-register and PC controls.
    typedef struct packed {
        logic pc_en;
        logic en_if_id;
        logic fl_if_id;
        logic en_id_ex;
        logic fl_id_ex;
        logic en_ex_mem;
        logic fl_ex_mem;
        logic en_mem_wb;
    } hazard_ctrl_t;

    localparam hazard_ctrl_t CTRL_RUN = '{pc_en: 1'b1, en_if_id: 1'b1, fl_if_id: 1'b0,
                                          en_id_ex: 1'b1, fl_id_ex: 1'b0, en_ex_mem: 1'b1,
                                          fl_ex_mem: 1'b0, en_mem_wb: 1'b1};
    localparam hazard_ctrl_t CTRL_FREEZE = '0;
    localparam hazard_ctrl_t CTRL_HALT = '{pc_en: 1'b0, en_if_id: 1'b1, fl_if_id: 1'b1,
                                           en_id_ex: 1'b1, fl_id_ex: 1'b1, en_ex_mem: 1'b1,
                                           fl_ex_mem: 1'b1, en_mem_wb: 1'b1};
    localparam hazard_ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, en_if_id: 1'b1, fl_if_id: 1'b1,
                                             en_id_ex: 1'b1, fl_id_ex: 1'b1, en_ex_mem: 1'b1,
                                             fl_ex_mem: 1'b0, en_mem_wb: 1'b1};
    localparam hazard_ctrl_t CTRL_JUMP = '{pc_en: 1'b1, en_if_id: 1'b1, fl_if_id: 1'b1,
                                           en_id_ex: 1'b1, fl_id_ex: 1'b0, en_ex_mem: 1'b1,
                                           fl_ex_mem: 1'b0, en_mem_wb: 1'b1};
    localparam hazard_ctrl_t CTRL_LOADUSE = '{pc_en: 1'b0, en_if_id: 1'b0, fl_if_id: 1'b0,
                                              en_id_ex: 1'b1, fl_id_ex: 1'b1, en_ex_mem: 1'b1,
                                              fl_ex_mem: 1'b0, en_mem_wb: 1'b1};
    localparam hazard_ctrl_t CTRL_NOFETCH = '{pc_en: 1'b0, en_if_id: 1'b1, fl_if_id: 1'b1,
                                              en_id_ex: 1'b1, fl_id_ex: 1'b0, en_ex_mem: 1'b1,
                                              fl_ex_mem: 1'b0, en_mem_wb: 1'b1};
    localparam hazard_ctrl_t CTRL_RESET = '{pc_en: 1'b0, en_if_id: 1'b1, fl_if_id: 1'b0,
                                            en_id_ex: 1'b1, fl_id_ex: 1'b0, en_ex_mem: 1'b1,
                                            fl_ex_mem: 1'b0, en_mem_wb: 1'b1};

    // $zero is never a real producer, so a load into r0 cannot create a hazard.
    function automatic logic is_loaduse(input logic       dren_ex,
                                         input logic [4:0] rt_ex,
                                         input logic [4:0] rs_id,
                                         input logic [4:0] rt_id);
        return dren_ex && (rt_ex != 5'd0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of every non-clock/reset signal of hazard_unit, with block and bench views.
interface hazard_unit_if
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = HAZ_CNT_W
);
    logic             ihit;
    logic             dhit;
    logic             dREN_EX_MEM;
    logic             dWEN_EX_MEM;
    logic             dREN_ID_EX;
    logic [4:0]       Rt_ID_EX;
    logic [4:0]       Rs_IF_ID;
    logic [4:0]       Rt_IF_ID;
    logic             branch_taken_EX;
    logic             jump_ID;
    logic             halt_MEM;
    logic             pc_en;
    logic             enable_IF_ID;
    logic             flush_IF_ID;
    logic             enable_ID_EX;
    logic             flush_ID_EX;
    logic             enable_EX_MEM;
    logic             flush_EX_MEM;
    logic             enable_MEM_WB;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport hu (
        input  ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, dREN_ID_EX, Rt_ID_EX, Rs_IF_ID,
               Rt_IF_ID, branch_taken_EX, jump_ID, halt_MEM,
        output pc_en, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX,
               enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, halt, stall_cnt, flush_cnt
    );

    modport tb (
        output ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, dREN_ID_EX, Rt_ID_EX, Rs_IF_ID,
               Rt_IF_ID, branch_taken_EX, jump_ID, halt_MEM,
        input  pc_en, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX,
               enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, halt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; used for the stall and flush statistics.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         clear_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/hazard_unit.sv
// Pipeline sequencing controller: arbitrates memory waits, redirects, load-use
// and halt into per-stage enable/flush controls, plus stall/flush statistics.
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = HAZ_CNT_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_EX_MEM,
    input  logic             dWEN_EX_MEM,
    input  logic             dREN_ID_EX,
    input  logic [4:0]       Rt_ID_EX,
    input  logic [4:0]       Rs_IF_ID,
    input  logic [4:0]       Rt_IF_ID,
    input  logic             branch_taken_EX,
    input  logic             jump_ID,
    input  logic             halt_MEM,
    output logic             pc_en,
    output logic             enable_IF_ID,
    output logic             flush_IF_ID,
    output logic             enable_ID_EX,
    output logic             flush_ID_EX,
    output logic             enable_EX_MEM,
    output logic             flush_EX_MEM,
    output logic             enable_MEM_WB,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    hazard_state_t state_q;
    hazard_state_t state_d;
    hazard_ctrl_t  ctrl;
    logic          memstall;
    logic          loaduse;
    logic          stall_inc;
    logic          flush_inc;

    assign memstall = (dREN_EX_MEM | dWEN_EX_MEM) & ~dhit;
    assign loaduse  = is_loaduse(dREN_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl      = CTRL_RUN;
        state_d   = state_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            HALT: begin
                ctrl = CTRL_FREEZE;
            end
            default: begin
                // MEM_WAIT shares the RUN priority chain: once dhit arrives the
                // memstall term drops and the lower rules decide this cycle.
                state_d = RUN;
                if (halt_MEM) begin
                    ctrl    = CTRL_HALT;
                    state_d = HALT;
                end else if (memstall) begin
                    ctrl    = CTRL_FREEZE;
                    state_d = MEM_WAIT;
                end else if (branch_taken_EX) begin
                    ctrl      = CTRL_BRANCH;
                    flush_inc = 1'b1;
                end else if (jump_ID) begin
                    ctrl      = CTRL_JUMP;
                    flush_inc = 1'b1;
                end else if (loaduse) begin
                    ctrl = CTRL_LOADUSE;
                end else if (!ihit) begin
                    ctrl = CTRL_NOFETCH;
                end
                stall_inc = ~ctrl.pc_en & ~halt_MEM;
            end
        endcase
        if (!nRST) begin
            ctrl = CTRL_RESET;
        end
    end

    assign pc_en         = ctrl.pc_en;
    assign enable_IF_ID  = ctrl.en_if_id;
    assign flush_IF_ID   = ctrl.fl_if_id;
    assign enable_ID_EX  = ctrl.en_id_ex;
    assign flush_ID_EX   = ctrl.fl_id_ex;
    assign enable_EX_MEM = ctrl.en_ex_mem;
    assign flush_EX_MEM  = ctrl.fl_ex_mem;
    assign enable_MEM_WB = ctrl.en_mem_wb;
    assign halt          = (state_q == HALT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .inc_i   (stall_inc),
        .clear_i (1'b0),
        .count_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .inc_i   (flush_inc),
        .clear_i (1'b0),
        .count_o (flush_cnt)
    );
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Each cycle it drives the enable/flush pair of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Inputs it arbitrates: memory wait states, taken branches and jumps, load-use hazards and halt.
- Holds a small run/wait/halt FSM and saturating performance counters for stall and flush cycles.

Parameters:
- CNT_W, 16, width of stall_cnt and flush_cnt.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction word valid this cycle
- dhit  in  1  data access complete this cycle
- dREN_EX_MEM  in  1  MEM-stage instruction reads memory
- dWEN_EX_MEM  in  1  MEM-stage instruction writes memory
- dREN_ID_EX  in  1  EX-stage instruction is a load
- Rt_ID_EX  in  5  load destination register in EX
- Rs_IF_ID  in  5  source register rs in ID
- Rt_IF_ID  in  5  source register rt in ID
- branch_taken_EX  in  1  branch resolved taken in EX
- jump_ID  in  1  J/JAL/JR decoded in ID
- halt_MEM  in  1  HALT instruction in MEM
- pc_en  out  1  PC register write enable
- enable_IF_ID, flush_IF_ID  out  1 each
- enable_ID_EX, flush_ID_EX  out  1 each
- enable_EX_MEM, flush_EX_MEM  out  1 each
- enable_MEM_WB  out  1
- halt  out  1  sticky halt to system
- stall_cnt  out  CNT_W  saturating count of PC-frozen cycles
- flush_cnt  out  CNT_W  saturating count of redirect cycles

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous and active-low.
- Reset values: state=RUN, stall_cnt=0, flush_cnt=0, halt=0.
- Control outputs are combinational from state and inputs. At the same time reset is asserted, flush outputs are 0 and enables are 1.
- Flush has priority over enable in every pipeline register. When this block asserts flush it also drives enable=1.
- memstall = (dREN_EX_MEM | dWEN_EX_MEM) & ~dhit.
- loaduse = dREN_ID_EX & (Rt_ID_EX != 0) & (Rt_ID_EX == Rs_IF_ID | Rt_ID_EX == Rt_IF_ID).
- FSM states: RUN, MEM_WAIT, HALT.
- In RUN and MEM_WAIT, only the first matching rule applies per cycle:
  - P1 halt_MEM: pc_en=0; flush IF_ID, ID_EX and EX_MEM; enable_MEM_WB=1; next=HALT.
  - P2 memstall: all enables=0, all flushes=0, pc_en=0; next=MEM_WAIT.
  - P3 branch_taken_EX: pc_en=1; flush IF_ID and ID_EX; enable EX_MEM and MEM_WB. branch_taken_EX dominates jump_ID.
  - P4 jump_ID: pc_en=1; flush IF_ID only; other stages enabled.
  - P5 loaduse: pc_en=0, enable_IF_ID=0, flush_ID_EX=1; EX_MEM and MEM_WB enabled.
  - P6 ~ihit: pc_en=0, flush_IF_ID=1; others enabled.
  - P7 otherwise: all enables=1, pc_en=1, no flush.
- Next state for P3 through P7 is RUN. MEM_WAIT returns to RUN on the first cycle that dhit=1.
- HALT: pc_en=0, all enables=0, all flushes=0, halt=1.
  - HALT persists until nRST; all inputs are ignored.
  - halt is registered: it goes high the cycle after P1 fires.
- stall_cnt increments on any RUN or MEM_WAIT cycle with pc_en=0, excluding P1. It saturates at all-ones.
- flush_cnt increments on P3 and P4 cycles. It saturates at all-ones.
- Reset asserted mid-stall or mid-halt returns state, counters and halt to their reset values immediately (asynchronous).

Decomposition:
- cpu_types_pkg gains:
  - hazard_state_t enum {RUN, MEM_WAIT, HALT}
  - constant HAZ_CNT_W = 16
- A hazard_unit_if interface bundles all non-clock/reset ports, with modports hu (block) and tb (bench).
- Optional sub-module sat_counter (parameter W; inputs inc, clear). It is instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
- Reset, then ihit=1 and no hazards for 5 cycles -> pc_en=1, all enables=1, no flushes, stall_cnt=0, flush_cnt=0, halt=0.
- dREN_ID_EX=1, Rt_ID_EX=8, Rs_IF_ID=8, ihit=1 -> pc_en=0, enable_IF_ID=0, flush_ID_EX=1 for one cycle; stall_cnt=1. Repeat with Rt_ID_EX=0 -> no stall.
- dWEN_EX_MEM=1, dhit=0 for 3 cycles, then dhit=1 -> all enables 0 for 3 cycles with state=MEM_WAIT; RUN on the dhit cycle; stall_cnt=3.
- branch_taken_EX=1 and jump_ID=1 in the same cycle -> flush_IF_ID=1, flush_ID_EX=1, pc_en=1, flush_cnt=1. jump_ID alone -> flush_IF_ID=1 only, flush_cnt=2.
- halt_MEM=1 together with memstall -> P1 wins: EX_MEM flushed, MEM_WB enabled. Next cycle halt=1 and all enables 0, holding through 10 cycles of random input. nRST pulse -> halt=0, state=RUN.
- Force 2^CNT_W+5 ~ihit cycles -> stall_cnt holds at 16'hFFFF.
